// File: rtl/vga_layer_arbiter.sv
// Per-pixel layer arbiter for the VGA path: fixed-priority object selection over a background,
// a frame-synchronous layer-enable mask and per-frame overlap flags for the game logic.
module vga_layer_arbiter #(
    parameter int unsigned             N_LAYERS          = 4,
    parameter logic [7:0]              TRANSPARENT_COLOR = 8'hFF,
    parameter logic [N_LAYERS-1:0]     EN_RESET          = '1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic [N_LAYERS-1:0]       layerEnShadow,
    input  logic [N_LAYERS-1:0]       drawReq,
    input  logic [8*N_LAYERS-1:0]     rgbIn,
    input  logic [7:0]                bgRGB,
    output logic [7:0]                RGBOut,
    output logic                      layerValid,
    output logic [2:0]                activeLayer,
    output logic [N_LAYERS-1:0]       layerEnActive,
    output logic [N_LAYERS-1:0]       collisionFlags,
    output logic                      collisionPulse
);

    localparam int unsigned RGB_W = 8;
    localparam int unsigned IDX_W = 3;

    logic [N_LAYERS-1:0] eff;
    logic [N_LAYERS-1:0] acc;
    logic [N_LAYERS-1:0] acc_next;
    logic                multi;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [RGB_W-1:0]    win_rgb;

    // Effective requests: drawing, enabled by the active mask, and not transparent.
    always_comb begin
        eff = '0;
        for (int i = 0; i < int'(N_LAYERS); i++) begin
            eff[i] = drawReq[i] & layerEnActive[i] &
                     (rgbIn[RGB_W*i +: RGB_W] != TRANSPARENT_COLOR);
        end
    end

    // Scan from lowest priority upward so the lowest set index is the last to win.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_rgb   = bgRGB;
        for (int i = int'(N_LAYERS) - 1; i >= 0; i--) begin
            if (eff[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_rgb   = rgbIn[RGB_W*i +: RGB_W];
            end
        end
    end

    // Two or more set bits exactly when clearing the lowest set bit leaves something behind.
    always_comb begin
        multi    = |(eff & (eff - N_LAYERS'(1)));
        acc_next = acc | (eff & {N_LAYERS{multi}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RGBOut      <= '0;
            layerValid  <= 1'b0;
            activeLayer <= '0;
        end else begin
            RGBOut      <= win_rgb;
            layerValid  <= win_found;
            activeLayer <= win_idx;
        end
    end

    // Mask and overlap publication both swap at frame start; the current cycle still uses the old mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            layerEnActive  <= EN_RESET;
            acc            <= '0;
            collisionFlags <= '0;
            collisionPulse <= 1'b0;
        end else if (startOfFrame) begin
            layerEnActive  <= layerEnShadow;
            acc            <= '0;
            collisionFlags <= acc_next;
            collisionPulse <= |acc_next;
        end else begin
            acc            <= acc_next;
            collisionPulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_layer_arbiter.sv
// Self-checking bench for vga_layer_arbiter: directed frame scenarios plus randomized traffic
// compared against a behavioural per-pixel model.
module tb_vga_layer_arbiter;

    logic        clk;
    logic        reset;
    logic        startOfFrame;
    logic [3:0]  layerEnShadow;
    logic [3:0]  drawReq;
    logic [31:0] rgbIn;
    logic [7:0]  bgRGB;
    logic [7:0]  RGBOut;
    logic        layerValid;
    logic [2:0]  activeLayer;
    logic [3:0]  layerEnActive;
    logic [3:0]  collisionFlags;
    logic        collisionPulse;

    vga_layer_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .layerEnShadow  (layerEnShadow),
        .drawReq        (drawReq),
        .rgbIn          (rgbIn),
        .bgRGB          (bgRGB),
        .RGBOut         (RGBOut),
        .layerValid     (layerValid),
        .activeLayer    (activeLayer),
        .layerEnActive  (layerEnActive),
        .collisionFlags (collisionFlags),
        .collisionPulse (collisionPulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [3:0] m_mask  = 4'hF;
    logic [3:0] m_acc   = 4'h0;
    logic [3:0] m_flags = 4'h0;
    logic       m_pulse = 1'b0;
    logic [7:0] m_rgb   = 8'h00;
    logic       m_valid = 1'b0;
    int         m_idx   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Apply one pixel of stimulus, advance the model, then compare every output after the edge.
    task automatic pixel(input logic rst, input logic sof, input logic [3:0] shadow,
                         input logic [3:0] req, input logic [31:0] rgb, input logic [7:0] bg);
        int         winners[$];
        logic [3:0] overlap;
        logic [7:0] slice;
        reset         = rst;
        startOfFrame  = sof;
        layerEnShadow = shadow;
        drawReq       = req;
        rgbIn         = rgb;
        bgRGB         = bg;
        for (int i = 0; i < 4; i++) begin
            slice = rgb[8*i +: 8];
            if (req[i] && m_mask[i] && slice != 8'hFF) winners.push_back(i);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_rgb = 8'h00; m_valid = 1'b0; m_idx = 0;
            m_mask = 4'hF; m_acc = 4'h0; m_flags = 4'h0; m_pulse = 1'b0;
        end else begin
            if (winners.size() > 0) begin
                m_idx = winners[0]; m_valid = 1'b1; m_rgb = rgb[8*m_idx +: 8];
            end else begin
                m_idx = 0; m_valid = 1'b0; m_rgb = bg;
            end
            overlap = 4'h0;
            if (winners.size() >= 2) foreach (winners[k]) overlap[winners[k]] = 1'b1;
            if (sof) begin
                m_flags = m_acc | overlap;
                m_pulse = (m_flags != 4'h0);
                m_acc   = 4'h0;
                m_mask  = shadow;
            end else begin
                m_acc   = m_acc | overlap;
                m_pulse = 1'b0;
            end
        end
        check("rgb",     32'(RGBOut),         32'(m_rgb));
        check("valid",   32'(layerValid),     32'(m_valid));
        check("idx",     32'(activeLayer),    32'(m_idx));
        check("mask",    32'(layerEnActive),  32'(m_mask));
        check("flags",   32'(collisionFlags), 32'(m_flags));
        check("pulse",   32'(collisionPulse), 32'(m_pulse));
    endtask

    initial begin
        logic [31:0] rgb_r;
        logic [7:0]  b;
        // Reset and background passthrough
        pixel(1, 0, 4'hF, 4'h0, 32'h0, 8'h00);
        check("rst_mask", 32'(layerEnActive), 32'h0000000F);
        check("rst_rgb",  32'(RGBOut),        32'h00000000);
        pixel(0, 0, 4'hF, 4'h0, 32'h0, 8'h1C);
        check("bg_rgb",   32'(RGBOut),        32'h0000001C);
        check("bg_valid", 32'(layerValid),    32'h00000000);

        // Priority and transparency
        pixel(0, 0, 4'hF, 4'b0110, {8'h00, 8'h03, 8'hE0, 8'h00}, 8'h1C);
        check("prio_rgb", 32'(RGBOut),      32'h000000E0);
        check("prio_idx", 32'(activeLayer), 32'h00000001);
        pixel(0, 0, 4'hF, 4'b0110, {8'h00, 8'h03, 8'hFF, 8'h00}, 8'h1C);
        check("transp_rgb", 32'(RGBOut),      32'h00000003);
        check("transp_idx", 32'(activeLayer), 32'h00000002);
        pixel(0, 1, 4'hF, 4'h0, 32'h0, 8'h1C);
        check("prio_flags", 32'(collisionFlags), 32'h00000006);

        // Enable mask applied only at frame start
        pixel(0, 0, 4'b1101, 4'b0010, {8'h00, 8'h00, 8'h55, 8'h00}, 8'h1C);
        check("shadow_mid", 32'(RGBOut), 32'h00000055);
        pixel(0, 1, 4'b1101, 4'b0010, {8'h00, 8'h00, 8'h55, 8'h00}, 8'h1C);
        check("shadow_sof", 32'(RGBOut), 32'h00000055);
        pixel(0, 0, 4'b1101, 4'b0010, {8'h00, 8'h00, 8'h55, 8'h00}, 8'h1C);
        check("shadow_mask", 32'(layerEnActive), 32'h0000000D);
        check("shadow_bg",   32'(RGBOut),        32'h0000001C);

        // Collision publication and one-cycle pulse
        pixel(0, 1, 4'hF, 4'h0, 32'h0, 8'h1C);
        pixel(0, 0, 4'hF, 4'b1001, {8'h22, 8'h00, 8'h00, 8'h11}, 8'h1C);
        pixel(0, 0, 4'hF, 4'h0, 32'h0, 8'h1C);
        pixel(0, 1, 4'hF, 4'h0, 32'h0, 8'h1C);
        check("coll_flags", 32'(collisionFlags), 32'h00000009);
        check("coll_pulse", 32'(collisionPulse), 32'h00000001);
        pixel(0, 0, 4'hF, 4'h0, 32'h0, 8'h1C);
        check("coll_pulse_end", 32'(collisionPulse), 32'h00000000);
        pixel(0, 1, 4'hF, 4'h0, 32'h0, 8'h1C);
        check("coll_clear", 32'(collisionFlags), 32'h00000000);

        // Overlap on the frame-start cycle itself
        pixel(0, 1, 4'hF, 4'b0011, {8'h00, 8'h00, 8'h44, 8'h33}, 8'h1C);
        check("sof_overlap", 32'(collisionFlags), 32'h00000003);
        pixel(0, 0, 4'hF, 4'h0, 32'h0, 8'h1C);
        pixel(0, 1, 4'hF, 4'h0, 32'h0, 8'h1C);
        check("sof_acc_empty", 32'(collisionFlags), 32'h00000000);

        // Reset mid-frame drops accumulator and restores the mask at once
        pixel(0, 1, 4'b0111, 4'h0, 32'h0, 8'h1C);
        pixel(0, 0, 4'b0111, 4'b0011, {8'h00, 8'h00, 8'h44, 8'h33}, 8'h1C);
        pixel(1, 0, 4'b0111, 4'h0, 32'h0, 8'h1C);
        check("rst_mid_mask", 32'(layerEnActive), 32'h0000000F);
        pixel(0, 1, 4'hF, 4'h0, 32'h0, 8'h1C);
        check("rst_mid_flags", 32'(collisionFlags), 32'h00000000);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                b = 8'($urandom);
                if ($urandom_range(0, 3) == 0) b = 8'hFF;
                rgb_r[8*i +: 8] = b;
            end
            pixel(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
                  4'($urandom), 4'($urandom), rgb_r, 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_layer_arbiter.md
Name: vga_layer_arbiter

Overview:
- Per-pixel arbiter that shares the single 8-bit RGB input of the VGA controller between N drawing objects (ball, players, goals, score) and a background.
- Selects the highest-priority enabled requester each pixel clock and registers the chosen colour.
- Applies a per-frame layer-enable mask, double-buffered on startOfFrame so that changes never tear mid-frame.
- Accumulates per-layer overlap (collision) flags over a frame and publishes them at frame start for the game logic.

Parameters:
- N_LAYERS, 4, number of object requesters; 2..8 supported.
- TRANSPARENT_COLOR, 8'hFF, an object pixel of this colour is treated as no request.
- EN_RESET, all ones (N_LAYERS bits), active enable mask after reset.

Ports:
- clk  in  1  pixel clock, same clock as the VGA controller.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  single-cycle frame-start pulse from the VGA controller.
- layerEnShadow  in  N_LAYERS  requested enable mask; sampled only on startOfFrame.
- drawReq  in  N_LAYERS  per-layer drawing request for the current pixel.
- rgbIn  in  8*N_LAYERS  per-layer colour; layer i occupies bits [8i+7:8i].
- bgRGB  in  8  background colour for the current pixel.
- RGBOut  out  8  arbitrated colour, drives the VGA controller RGBIn.
- layerValid  out  1  an object (not background) won this pixel.
- activeLayer  out  3  index of the winning layer; 0 when layerValid=0.
- layerEnActive  out  N_LAYERS  enable mask currently in force.
- collisionFlags  out  N_LAYERS  per-layer overlap flags for the previous frame.
- collisionPulse  out  1  one-cycle pulse at frame start if any flag is set.

Behaviour:
- All state is updated on posedge clk. reset has priority over every other input.
- Reset values:
  - RGBOut=8'h00, layerValid=0, activeLayer=0.
  - layerEnActive=EN_RESET.
  - collisionFlags=0, collisionPulse=0, internal accumulator=0.
- Effective request, combinational: eff[i] = drawReq[i] & layerEnActive[i] & (rgbIn slice i != TRANSPARENT_COLOR).
- Priority: fixed; lowest index wins (layer 0 is highest).
- Latency: inputs sampled in cycle t appear on RGBOut, layerValid and activeLayer in cycle t+1. Exactly one register stage, no bubbles, one pixel per clock.
  - If any eff bit is set: RGBOut <= winner's rgb, layerValid <= 1, activeLayer <= winner index.
  - Otherwise: RGBOut <= bgRGB, layerValid <= 0, activeLayer <= 0.
- Enable double-buffer: layerEnActive <= layerEnShadow only in a cycle where startOfFrame=1.
  - Arbitration in that same cycle still uses the old layerEnActive.
  - The new mask takes effect from the next cycle.
- Overlap accumulator acc[N_LAYERS]:
  - multi = (number of set eff bits >= 2).
  - acc_next[i] = acc[i] | (eff[i] & multi).
  - Outside startOfFrame: acc <= acc_next.
  - On startOfFrame: collisionFlags <= acc_next (includes the current cycle), collisionPulse <= |acc_next, acc <= 0.
  - Otherwise collisionPulse <= 0; collisionFlags hold their value.
- Overlap uses effective requests only: disabled or transparent pixels never count as collisions. Only layers involved in an overlap are flagged; the lowest-priority loser is flagged as well as the winner.
- startOfFrame on consecutive cycles: each cycle acts independently. The second cycle publishes only its own overlap, typically 0, which clears the flags.
- Reset mid-frame: the accumulator is discarded and the enable mask returns to EN_RESET immediately, not at the next frame.
- Blanking: no special handling. Requesters must deassert drawReq outside the active area; the block still arbitrates during blanking.
- Widths: activeLayer is fixed at 3 bits; upper bits are 0 when N_LAYERS<=4.

Test Plan:
- Reset, then drawReq=0, bgRGB=8'h1C → cycle t+1: RGBOut=8'h1C, layerValid=0, activeLayer=0; all flags 0.
- drawReq=4'b0110, rgbIn layer1=8'hE0, layer2=8'h03 → next cycle: RGBOut=8'hE0, activeLayer=1. Layer1 rgb=8'hFF (transparent) → RGBOut=8'h03, activeLayer=2.
- layerEnShadow=4'b1101 driven mid-frame, drawReq=4'b0010, rgb1=8'h55 → RGBOut=8'h55 until startOfFrame. Cycle after the pulse: layerEnActive=4'b1101, RGBOut=bgRGB.
- During a frame, one cycle with drawReq=4'b1001 (both enabled, opaque), then startOfFrame → collisionFlags=4'b1001 and collisionPulse=1 for exactly one cycle. The following frame has no overlap → next startOfFrame gives flags=0, pulse=0.
- Overlap drawReq=4'b0011 coincident with the startOfFrame cycle → included in the published flags (4'b0011). The accumulator is empty afterwards; verify the next frame's flags stay 0.
- reset asserted one cycle mid-frame after an overlap → next startOfFrame publishes collisionFlags=0, and layerEnActive=EN_RESET immediately after reset.
